dense_layer_stream: RTL and testbench

- Parametrised fixed-point dense layer: out[n] = act(sum_i in[i]*W[n][i] + b[n]).
- Computes LANES neurons in parallel per pass; weights and biases are read from external synchronous memories.
- Input vector arrives on a valid/ready stream; results leave on a valid/ready stream with an index.
- Sits between layers in the MLP datapath; instances chain output stream to input stream.

---
 rtl/dense_layer_stream.sv | 218 +++++++++++++++++++++
 tb/tb_dense_layer_stream.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_stream.sv
// Streaming fixed-point dense layer: buffers one input vector, then evaluates
// LANES neurons per pass against external weight/bias memories.
module dense_layer_stream #(
  parameter int N_INPUTS  = 784,
  parameter int N_NEURONS = 128,
  parameter int LANES     = 4,
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int ACC_W     = 40,
  localparam int N_GROUPS = N_NEURONS / LANES,
  localparam int WA_W     = (N_GROUPS * N_INPUTS > 1) ? $clog2(N_GROUPS * N_INPUTS) : 1,
  localparam int BA_W     = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  localparam int OI_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                      CLK,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [1:0]                act_mode,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      weight_rd,
  output logic [WA_W-1:0]           weight_addr,
  input  logic [LANES*DATA_W-1:0]   weight_data,
  output logic [BA_W-1:0]           bias_addr,
  input  logic [LANES*DATA_W-1:0]   bias_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [OI_W-1:0]           out_index,
  output logic                      out_last
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int LN_W  = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_ACT,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [BA_W-1:0]          grp_q, grp_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [LN_W-1:0]          lane_q, lane_d;
  logic signed [ACC_W-1:0]  acc_q [LANES];
  logic signed [ACC_W-1:0]  acc_d [LANES];
  logic signed [DATA_W-1:0] res_q [LANES];
  logic signed [DATA_W-1:0] res_d [LANES];

  logic [DATA_W-1:0]        inbuf [N_INPUTS];
  logic signed [DATA_W-1:0] x_cur;
  logic signed [ACC_W-1:0]  prod_x [LANES];
  logic signed [ACC_W-1:0]  bias_x [LANES];

  function automatic logic signed [DATA_W-1:0] activate(
    input logic signed [ACC_W-1:0] acc,
    input logic [1:0]              mode
  );
    logic signed [ACC_W-1:0] r;
    r = acc >>> FRAC_W;
    if (mode == 2'b01 && r[ACC_W-1]) begin
      r = '0;
    end else if (mode == 2'b10 && r[ACC_W-1]) begin
      r = r >>> 3;
    end
    if (r > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (r < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end
    return r[DATA_W-1:0];
  endfunction

  // MAC cycle k+1 consumes the memory word requested at cycle k.
  assign x_cur = inbuf[IDX_W'(cnt_q - 1'b1)];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_W-1:0]   w_l;
    logic signed [DATA_W-1:0]   b_l;
    logic signed [2*DATA_W-1:0] p_l;
    assign w_l       = weight_data[l*DATA_W +: DATA_W];
    assign b_l       = bias_data[l*DATA_W +: DATA_W];
    assign p_l       = x_cur * w_l;
    assign prod_x[l] = ACC_W'(p_l);
    assign bias_x[l] = ACC_W'(b_l) <<< FRAC_W;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    grp_d   = grp_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = act_mode;
          grp_d   = '0;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
            cnt_d   = '0;
            state_d = S_MAC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (cnt_q == CNT_W'(1)) begin
            acc_d[l] = bias_x[l] + prod_x[l];
          end else if (cnt_q != '0) begin
            acc_d[l] = acc_q[l] + prod_x[l];
          end
        end
        if (cnt_q == CNT_W'(N_INPUTS)) begin
          cnt_d   = '0;
          state_d = S_ACT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACT: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          res_d[l] = activate(acc_q[l], mode_q);
        end
        lane_d  = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (lane_q == LN_W'(LANES - 1)) begin
            lane_d = '0;
            if (grp_q == BA_W'(N_GROUPS - 1)) begin
              state_d = S_FIN;
            end else begin
              grp_d   = grp_q + 1'b1;
              state_d = S_MAC;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      grp_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
        res_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      grp_q   <= grp_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == S_LOAD && in_valid) begin
      inbuf[IDX_W'(cnt_q)] <= in_data;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign in_ready    = (state_q == S_LOAD);
  assign weight_rd   = (state_q == S_MAC) && (cnt_q != CNT_W'(N_INPUTS));
  assign weight_addr = weight_rd
                     ? WA_W'(grp_q) * WA_W'(N_INPUTS) + WA_W'(cnt_q)
                     : '0;
  assign bias_addr   = weight_rd ? grp_q : '0;
  assign out_valid   = (state_q == S_DRAIN);
  assign out_data    = out_valid ? res_q[lane_q] : '0;
  assign out_index   = out_valid
                     ? OI_W'(grp_q) * OI_W'(LANES) + OI_W'(lane_q)
                     : '0;
  assign out_last    = out_valid && (out_index == OI_W'(N_NEURONS - 1));

endmodule

// File: tb/tb_dense_layer_stream.sv
// Scoreboard bench for dense_layer_stream: expected outputs queued per run from
// an arithmetic reference model, popped by an independent output monitor.
module tb_dense_layer_stream;
  localparam int N    = 4;
  localparam int NN   = 4;
  localparam int L    = 2;
  localparam int DW   = 16;
  localparam int FW   = 8;
  localparam int AW   = 40;
  localparam int G    = NN / L;
  localparam int WA_W = 3;
  localparam int BA_W = 1;
  localparam int OI_W = 2;
  localparam int PER  = 10;
  localparam int LAT  = N + G * (N + 2 + L) + 1;

  logic              CLK, reset_n, start;
  logic [1:0]        act_mode;
  logic              busy, done, in_valid, in_ready;
  logic [DW-1:0]     in_data;
  logic              weight_rd;
  logic [WA_W-1:0]   weight_addr;
  logic [L*DW-1:0]   weight_data;
  logic [BA_W-1:0]   bias_addr;
  logic [L*DW-1:0]   bias_data;
  logic              out_valid, out_ready;
  logic [DW-1:0]     out_data;
  logic [OI_W-1:0]   out_index;
  logic              out_last;

  dense_layer_stream #(
    .N_INPUTS (N),
    .N_NEURONS(NN),
    .LANES    (L),
    .DATA_W   (DW),
    .FRAC_W   (FW),
    .ACC_W    (AW)
  ) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .start      (start),
    .act_mode   (act_mode),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .weight_rd  (weight_rd),
    .weight_addr(weight_addr),
    .weight_data(weight_data),
    .bias_addr  (bias_addr),
    .bias_data  (bias_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last)
  );

  initial CLK = 1'b0;
  always #(PER/2) CLK = ~CLK;

  logic [DW-1:0] in_v [N];
  logic [DW-1:0] w_v  [NN][N];
  logic [DW-1:0] b_v  [NN];

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    bit            last;
  } exp_t;
  exp_t exp_q[$];

  int  vectors = 0;
  int  miscompares = 0;
  int  done_cnt = 0;
  time start_t, done_t;
  bit  stall_req = 0, rand_ready = 0;
  int  stall_cnt = 0;
  bit  hold_chk = 0, hold_l = 0, last_hs_prev = 0, prev_done = 0;
  logic [DW-1:0]   hold_d;
  logic [OI_W-1:0] hold_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] expv(input int n, input logic [1:0] mode);
    longint s, r;
    longint hi, lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    s = longint'($signed(b_v[n])) * (longint'(1) << FW);
    for (int i = 0; i < N; i++)
      s += longint'($signed(in_v[i])) * longint'($signed(w_v[n][i]));
    r = s >>> FW;
    if (mode == 2'b01 && r < 0) r = 0;
    if (mode == 2'b10 && r < 0) r = r >>> 3;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return DW'(r);
  endfunction

  // Synchronous weight/bias memories, one-cycle read latency.
  always @(posedge CLK) begin
    if (weight_rd) begin
      for (int l = 0; l < L; l++) begin
        weight_data[l*DW +: DW] <= w_v[(int'(weight_addr) / N) * L + l][int'(weight_addr) % N];
        bias_data[l*DW +: DW]   <= b_v[int'(bias_addr) * L + l];
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (stall_req && out_valid && out_index == OI_W'(1) && stall_cnt < 5) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (!reset_n) begin
      hold_chk     = 0;
      last_hs_prev = 0;
      prev_done    = 0;
    end else begin
      if (hold_chk)
        chk("hold_stable", {out_valid, out_data, out_index, out_last},
            {1'b1, hold_d, hold_i, hold_l});
      hold_chk = out_valid && !out_ready;
      hold_d   = out_data;
      hold_i   = out_index;
      hold_l   = out_last;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {out_index, out_data}, 64'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_index_last", {out_index, out_last}, {OI_W'(e.idx), e.last});
        end
      end
      if (done) begin
        done_cnt++;
        done_t = $time;
        chk("done_after_last", last_hs_prev, 1);
      end
      if (prev_done) chk("busy_after_done", {busy, done}, 0);
      prev_done    = done;
      last_hs_prev = out_valid && out_ready && out_last;
    end
  end

  task automatic fill(input logic [DW-1:0] x, input logic [DW-1:0] w, input logic [DW-1:0] b);
    for (int n = 0; n < NN; n++) begin
      b_v[n] = b;
      for (int i = 0; i < N; i++) w_v[n][i] = w;
    end
    for (int i = 0; i < N; i++) in_v[i] = x;
  endtask

  function automatic logic [DW-1:0] rval();
    if ($urandom_range(0, 2) == 0) return DW'($urandom);
    return DW'(int'($urandom_range(0, 1023)) - 512);
  endfunction

  task automatic rand_fill();
    for (int n = 0; n < NN; n++) begin
      b_v[n] = rval();
      for (int i = 0; i < N; i++) w_v[n][i] = rval();
    end
    for (int i = 0; i < N; i++) in_v[i] = rval();
  endtask

  task automatic feed(input bit gaps);
    int i, t;
    bit hs;
    i = 0;
    t = 0;
    while (i < N && t < 300) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = in_v[i];
      end
      hs = in_valid && in_ready;
      @(negedge CLK);
      t++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    chk("load_complete", i, N);
    chk("in_ready_after_load", in_ready, 0);
  endtask

  task automatic begin_run(input logic [1:0] mode);
    @(negedge CLK);
    start    = 1'b1;
    act_mode = mode;
    start_t  = $time;
    @(negedge CLK);
    start    = 1'b0;
    act_mode = 2'($urandom);
  endtask

  task automatic run(input logic [1:0] mode, input bit gaps, input bit stall,
                     input bit rnd_ready, input bit mid_start, input bit chk_lat);
    int d0, t;
    for (int n = 0; n < NN; n++)
      exp_q.push_back('{idx: n, data: expv(n, mode), last: (n == NN - 1)});
    d0         = done_cnt;
    stall_cnt  = 0;
    stall_req  = stall;
    rand_ready = rnd_ready;
    begin_run(mode);
    feed(gaps);
    if (mid_start) begin
      repeat (2) @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 500) begin
      @(posedge CLK);
      t++;
    end
    @(negedge CLK);
    @(negedge CLK);
    chk("done_count", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
    if (chk_lat) chk("latency", (done_t - start_t) / PER, LAT);
    exp_q.delete();
    stall_req  = 0;
    rand_ready = 0;
  endtask

  task automatic reset_mid_run();
    int t;
    bit hit, bad;
    rand_fill();
    for (int n = 0; n < NN; n++)
      exp_q.push_back('{idx: n, data: expv(n, 2'b00), last: (n == NN - 1)});
    begin_run(2'b00);
    feed(0);
    t = 0;
    hit = 0;
    while (!hit && t < 200) begin
      @(negedge CLK);
      t++;
      hit = weight_rd && int'(weight_addr) >= N;
    end
    chk("reach_group1_mac", hit, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, in_ready, weight_rd, out_valid, out_last,
                          out_data, out_index, weight_addr, bias_addr}, 0);
    chk("group0_emitted", exp_q.size(), NN - L);
    exp_q.delete();
    @(negedge CLK);
    reset_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge CLK);
      if (out_valid || busy || done) bad = 1;
    end
    chk("quiet_after_reset", bad, 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    act_mode    = 2'b00;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    weight_data = '0;
    bias_data   = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {busy, done, in_ready, weight_rd, out_valid, out_last,
                          out_data, out_index, weight_addr, bias_addr}, 0);
    reset_n = 1'b1;

    fill(16'h0100, 16'h0080, 16'h0000);
    run(2'b00, 0, 0, 0, 0, 1);

    fill(16'h0100, 16'hFF80, 16'h0000);
    for (int m = 1; m < 4; m++) run(2'(m), 0, 0, 0, 0, 1);

    fill(16'h7F00, 16'h7F00, 16'h7FFF);
    run(2'b00, 0, 0, 0, 0, 0);
    fill(16'h7F00, 16'h8100, 16'h0000);
    run(2'b00, 0, 0, 0, 0, 0);
    fill(16'h0100, 16'h0000, 16'h8000);
    run(2'b10, 0, 0, 0, 0, 0);

    for (int n = 0; n < NN; n++) begin
      b_v[n] = DW'(n * 256);
      for (int i = 0; i < N; i++) w_v[n][i] = DW'((n + 1) * 256);
    end
    for (int i = 0; i < N; i++) in_v[i] = 16'h0100;
    run(2'b00, 1, 1, 0, 1, 0);

    repeat (8) begin
      rand_fill();
      run(2'($urandom_range(0, 3)), 1, 0, 1, 1'($urandom_range(0, 1)), 0);
    end

    reset_mid_run();
    rand_fill();
    run(2'($urandom_range(0, 3)), 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
